video_dnn_argmax_count: RTL and testbench
=========================================

Name: video_dnn_argmax_count

Overview:
Per-pixel class decision stage for the streaming DNN video path. Each class carries CHANNEL_WIDTH binary votes, and the block popcounts the votes for every class. It applies segmentation gating and a minimum-confidence threshold, then selects the winning class. Per-frame histograms of the winning classes are accumulated. It sits after the classification/segmentation merge and replaces the fixed 1-bit max-count stage with a generalised, multi-vote, pipelined version.

Parameters:
NUM_CLASS, 11, number of classes including background; background index = NUM_CLASS-1
CHANNEL_WIDTH, 4, binary votes per class
TUSER_WIDTH, 1, tuser width; bit 0 = frame start
TNUMBER_WIDTH, 4, width of winning-class index; must satisfy 2**TNUMBER_WIDTH >= NUM_CLASS
TCOUNT_WIDTH, 3, width of vote count; must satisfy 2**TCOUNT_WIDTH > CHANNEL_WIDTH
STAT_WIDTH, 20, per-class frame pixel counter width

Ports:
aresetn  in  1  asynchronous active-low reset
aclk  in  1  clock
param_min_count  in  TCOUNT_WIDTH  minimum winning vote count; quasi-static
param_bg_enable  in  1  1: force background when tseg=0
s_axi4s_tuser  in  TUSER_WIDTH  sideband
s_axi4s_tlast  in  1  end of line
s_axi4s_tdata  in  NUM_CLASS*CHANNEL_WIDTH  votes; class k occupies bits [k*CHANNEL_WIDTH +: CHANNEL_WIDTH]
s_axi4s_tseg  in  1  1 = foreground (digit) pixel
s_axi4s_tvalid  in  1  input valid
s_axi4s_tready  out  1  input ready
m_axi4s_tuser  out  TUSER_WIDTH  delayed tuser
m_axi4s_tlast  out  1  delayed tlast
m_axi4s_tnumber  out  TNUMBER_WIDTH  winning class index
m_axi4s_tcount  out  TCOUNT_WIDTH  winning vote count
m_axi4s_tdata  out  NUM_CLASS*CHANNEL_WIDTH  delayed input votes, after gating
m_axi4s_tvalid  out  1  output valid
m_axi4s_tready  in  1  output ready
stat_class_pixels  out  NUM_CLASS*STAT_WIDTH  winning-pixel counts of the previous frame
stat_valid  out  1  one-cycle pulse when stat_class_pixels updates

Behaviour:
- Reset: every output register, pipeline valid, stat counter and stat_class_pixels goes to 0, including stat_valid and m_axi4s_tvalid. The first_frame flag goes to 1.
- Pipeline: 3 register stages, gated by a common enable cke = !m_axi4s_tvalid || m_axi4s_tready. s_axi4s_tready = cke.
  - s_axi4s_tready is 0 during reset.
  - Latency from input handshake to m_axi4s_tvalid is exactly 3 cycles with no backpressure.
  - Throughput is 1 beat/cycle.
  - tvalid bubbles propagate as valid=0 stages. Data in invalid stages is don't-care.
- Stage 1, gating:
  - If param_bg_enable=1 and tseg=0: all foreground class votes are forced to 0, and the background class votes are forced to all ones.
  - If param_bg_enable=1 and tseg=1: background votes are forced to 0.
  - If param_bg_enable=0: votes pass unchanged.
  - Stage 1 registers the gated votes.
- Stage 2: popcount of each class's CHANNEL_WIDTH bits into TCOUNT_WIDTH bits, registered.
- Stage 3, argmax:
  - Maximum count wins. On a tie, the lowest class index wins.
  - If max count < param_min_count: tnumber = NUM_CLASS-1 and tcount = max count.
  - All counts 0 with param_min_count=0 gives tnumber=0, tcount=0.
  - Outputs are registered.
- Stalls: while m_axi4s_tvalid=1 and m_axi4s_tready=0, all output signals hold stable and no stage advances.
- Statistics:
  - Counted on each output handshake (m_axi4s_tvalid && m_axi4s_tready).
  - If the beat has tuser[0]=1 and first_frame=0: copy counters to stat_class_pixels, pulse stat_valid the same cycle as the registered update, and clear the counters. The beat's own class is then counted as 1 in the new frame.
  - If the beat has tuser[0]=1 and first_frame=1: no copy and no pulse. Counters clear and count this beat, and first_frame goes to 0.
  - Otherwise: counter[tnumber] += 1, saturating at 2**STAT_WIDTH-1.
- Reset mid-frame: all state is discarded, and the next frame start does not pulse stat_valid.

Test Plan:
1. Reset, then a single beat with class 3 = 4'b1111, all others 0, tseg=1, bg_enable=1, min_count=1 -> 3 cycles later tvalid=1, tnumber=3, tcount=4.
2. Tie: class 2 = 4'b0011 and class 7 = 4'b1100, others 0 -> tnumber=2, tcount=2.
3. tseg=0, bg_enable=1, any votes -> tnumber=10, tcount=4, tdata bits [43:40]=4'hF and all other bits 0.
4. min_count=3, class 5 = 4'b0101 as the maximum -> tnumber=10, tcount=2.
5. Random tready (50%) over 1000 beats -> no loss or duplication; output sequence matches the reference model; outputs stable while stalled.
6. Two frames of 4x2 pixels, frame 2 winners all class 1 -> no stat_valid at frame 1 start. At frame 2 start, stat_valid pulses once with the frame-1 histogram. At frame 3 start, stat_class_pixels class 1 = 8 and all other classes 0.

Source files
------------

// File: rtl/video_dnn_argmax_count.sv
// Per-pixel class decision stage for the streaming DNN video path.
// The block works in three pipeline stages:
//    1. segmentation gating of the votes,
//    2. a popcount of the votes for each class,
//    3. an argmax with a minimum-confidence threshold.
// It also keeps a histogram of winning classes for each frame and publishes
// the histogram of the previous frame at every frame start.
module video_dnn_argmax_count #(
   parameter int NUM_CLASS     = 11,
   parameter int CHANNEL_WIDTH = 4,
   parameter int TUSER_WIDTH   = 1,
   parameter int TNUMBER_WIDTH = 4,
   parameter int TCOUNT_WIDTH  = 3,
   parameter int STAT_WIDTH    = 20
) (
   input  logic                                aresetn,
   input  logic                                aclk,
   input  logic [TCOUNT_WIDTH-1:0]             param_min_count,
   input  logic                                param_bg_enable,
   input  logic [TUSER_WIDTH-1:0]              s_axi4s_tuser,
   input  logic                                s_axi4s_tlast,
   input  logic [NUM_CLASS*CHANNEL_WIDTH-1:0]  s_axi4s_tdata,
   input  logic                                s_axi4s_tseg,
   input  logic                                s_axi4s_tvalid,
   output logic                                s_axi4s_tready,
   output logic [TUSER_WIDTH-1:0]              m_axi4s_tuser,
   output logic                                m_axi4s_tlast,
   output logic [TNUMBER_WIDTH-1:0]            m_axi4s_tnumber,
   output logic [TCOUNT_WIDTH-1:0]             m_axi4s_tcount,
   output logic [NUM_CLASS*CHANNEL_WIDTH-1:0]  m_axi4s_tdata,
   output logic                                m_axi4s_tvalid,
   input  logic                                m_axi4s_tready,
   output logic [NUM_CLASS*STAT_WIDTH-1:0]     stat_class_pixels,
   output logic                                stat_valid
);

   localparam int VW = NUM_CLASS*CHANNEL_WIDTH;
   localparam int BG = NUM_CLASS-1;

   logic                     cke;
   logic                     out_hs;
   logic [VW-1:0]            gated;
   logic                     st1_valid;
   logic [VW-1:0]            st1_votes;
   logic [TUSER_WIDTH-1:0]   st1_user;
   logic                     st1_last;
   logic [TCOUNT_WIDTH-1:0]  pop [NUM_CLASS];
   logic                     st2_valid;
   logic [VW-1:0]            st2_votes;
   logic [TUSER_WIDTH-1:0]   st2_user;
   logic                     st2_last;
   logic [TCOUNT_WIDTH-1:0]  st2_cnt [NUM_CLASS];
   logic [TCOUNT_WIDTH-1:0]  best_cnt;
   logic [TNUMBER_WIDTH-1:0] best_idx;
   logic [TNUMBER_WIDTH-1:0] win_num;
   logic [STAT_WIDTH-1:0]    hist [NUM_CLASS];
   logic                     first_frame;

   // The whole pipeline moves together whenever the output slot is free.
   // The input is also held off while reset is asserted.
   assign cke            = !m_axi4s_tvalid || m_axi4s_tready;
   assign s_axi4s_tready = cke && aresetn;
   assign out_hs         = m_axi4s_tvalid && m_axi4s_tready;

   // Gating: a background pixel gets a full-confidence background vote.
   // A foreground pixel can never vote for background.
   always_comb begin
      gated = s_axi4s_tdata;
      if (param_bg_enable) begin
         if (!s_axi4s_tseg) begin
            gated = '0;
            gated[BG*CHANNEL_WIDTH +: CHANNEL_WIDTH] = '1;
         end else begin
            gated[BG*CHANNEL_WIDTH +: CHANNEL_WIDTH] = '0;
         end
      end
   end

   // Stage 1 register: the gated votes and their sideband.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         st1_valid <= 1'b0;
         st1_votes <= '0;
         st1_user  <= '0;
         st1_last  <= 1'b0;
      end else if (cke) begin
         st1_valid <= s_axi4s_tvalid;
         st1_votes <= gated;
         st1_user  <= s_axi4s_tuser;
         st1_last  <= s_axi4s_tlast;
      end
   end

   // Popcount of each class's votes taken from the stage 1 register.
   always_comb begin
      for (int k = 0; k < NUM_CLASS; k++) begin
         pop[k] = '0;
         for (int b = 0; b < CHANNEL_WIDTH; b++) begin
            pop[k] = pop[k] + TCOUNT_WIDTH'(st1_votes[k*CHANNEL_WIDTH + b]);
         end
      end
   end

   // Stage 2 register: per-class counts, with the votes carried along.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         st2_valid <= 1'b0;
         st2_votes <= '0;
         st2_user  <= '0;
         st2_last  <= 1'b0;
         for (int k = 0; k < NUM_CLASS; k++) st2_cnt[k] <= '0;
      end else if (cke) begin
         st2_valid <= st1_valid;
         st2_votes <= st1_votes;
         st2_user  <= st1_user;
         st2_last  <= st1_last;
         for (int k = 0; k < NUM_CLASS; k++) st2_cnt[k] <= pop[k];
      end
   end

   // Argmax uses a strict compare so that the lowest index wins a tie.
   // Results below the threshold fall back to background.
   always_comb begin
      best_cnt = '0;
      best_idx = '0;
      for (int k = 0; k < NUM_CLASS; k++) begin
         if (st2_cnt[k] > best_cnt) begin
            best_cnt = st2_cnt[k];
            best_idx = TNUMBER_WIDTH'(k);
         end
      end
      win_num = (best_cnt < param_min_count) ? TNUMBER_WIDTH'(BG) : best_idx;
   end

   // Stage 3 register: the outputs, which hold while the consumer stalls.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_axi4s_tvalid  <= 1'b0;
         m_axi4s_tdata   <= '0;
         m_axi4s_tuser   <= '0;
         m_axi4s_tlast   <= 1'b0;
         m_axi4s_tnumber <= '0;
         m_axi4s_tcount  <= '0;
      end else if (cke) begin
         m_axi4s_tvalid  <= st2_valid;
         m_axi4s_tdata   <= st2_votes;
         m_axi4s_tuser   <= st2_user;
         m_axi4s_tlast   <= st2_last;
         m_axi4s_tnumber <= win_num;
         m_axi4s_tcount  <= best_cnt;
      end
   end

   // Frame histogram of accepted output beats. A frame start publishes the
   // previous frame, except for the first frame after reset, which has no
   // complete predecessor.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         stat_valid        <= 1'b0;
         stat_class_pixels <= '0;
         first_frame       <= 1'b1;
         for (int k = 0; k < NUM_CLASS; k++) hist[k] <= '0;
      end else begin
         stat_valid <= 1'b0;
         if (out_hs) begin
            if (m_axi4s_tuser[0]) begin
               if (!first_frame) begin
                  for (int k = 0; k < NUM_CLASS; k++)
                     stat_class_pixels[k*STAT_WIDTH +: STAT_WIDTH] <= hist[k];
                  stat_valid <= 1'b1;
               end
               first_frame <= 1'b0;
               for (int k = 0; k < NUM_CLASS; k++)
                  hist[k] <= (TNUMBER_WIDTH'(k) == m_axi4s_tnumber) ? STAT_WIDTH'(1) : '0;
            end else begin
               for (int k = 0; k < NUM_CLASS; k++)
                  if (TNUMBER_WIDTH'(k) == m_axi4s_tnumber && hist[k] != '1)
                     hist[k] <= hist[k] + STAT_WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_video_dnn_argmax_count.sv
// Self-checking bench for video_dnn_argmax_count. A behavioural model
// predicts every output beat and every stat pulse. Directed cases pin the
// model to hand-computed values.
module tb_video_dnn_argmax_count;

   localparam int NC = 11;
   localparam int CW = 4;
   localparam int VW = NC*CW;
   localparam int SW = 20;

   typedef struct packed {
      logic          user;
      logic          last;
      logic [3:0]    num;
      logic [2:0]    cnt;
      logic [VW-1:0] data;
   } beat_t;

   logic                aresetn = 1'b0;
   logic                aclk = 1'b0;
   logic [2:0]          param_min_count = 3'd1;
   logic                param_bg_enable = 1'b1;
   logic [0:0]          s_tuser = '0;
   logic                s_tlast = 1'b0;
   logic [VW-1:0]       s_tdata = '0;
   logic                s_tseg = 1'b1;
   logic                s_tvalid = 1'b0;
   logic                s_tready;
   logic [0:0]          m_tuser;
   logic                m_tlast;
   logic [3:0]          m_tnumber;
   logic [2:0]          m_tcount;
   logic [VW-1:0]       m_tdata;
   logic                m_tvalid;
   logic                m_tready = 1'b1;
   logic [NC*SW-1:0]    stat_class_pixels;
   logic                stat_valid;

   int checks = 0;
   int errors = 0;
   int outputs_seen = 0;
   int stat_pulses = 0;
   logic [NC*SW-1:0] last_hist = '0;

   beat_t q[$];
   int    mhist[NC];
   logic  mfirst = 1'b1;
   logic  pend = 1'b0;
   logic [NC*SW-1:0] exp_hist = '0;
   logic  prev_stall = 1'b0;
   logic [53:0] held = '0;

   video_dnn_argmax_count dut (
      .aresetn(aresetn), .aclk(aclk),
      .param_min_count(param_min_count), .param_bg_enable(param_bg_enable),
      .s_axi4s_tuser(s_tuser), .s_axi4s_tlast(s_tlast), .s_axi4s_tdata(s_tdata),
      .s_axi4s_tseg(s_tseg), .s_axi4s_tvalid(s_tvalid), .s_axi4s_tready(s_tready),
      .m_axi4s_tuser(m_tuser), .m_axi4s_tlast(m_tlast), .m_axi4s_tnumber(m_tnumber),
      .m_axi4s_tcount(m_tcount), .m_axi4s_tdata(m_tdata), .m_axi4s_tvalid(m_tvalid),
      .m_axi4s_tready(m_tready), .stat_class_pixels(stat_class_pixels),
      .stat_valid(stat_valid)
   );

   // Free-running clock
   always #5 aclk = ~aclk;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference: gate, count the ones for each class, take the first maximum, apply the threshold
   function automatic beat_t model(input logic [VW-1:0] v, input logic seg, input logic bg,
                                   input logic [2:0] minc, input logic user, input logic last);
      beat_t e;
      int    cnt[NC];
      int    best;
      int    bi;
      e.data = v;
      if (bg) begin
         if (!seg) e.data = '0;
         for (int b = 0; b < CW; b++) e.data[(NC-1)*CW + b] = !seg;
      end
      best = 0;
      for (int k = 0; k < NC; k++) begin
         cnt[k] = $countones(e.data[k*CW +: CW]);
         if (cnt[k] > best) best = cnt[k];
      end
      bi = 0;
      for (int k = NC-1; k >= 0; k--) if (cnt[k] == best) bi = k;
      if (best < int'(minc)) bi = NC-1;
      e.num  = 4'(bi);
      e.cnt  = 3'(best);
      e.user = user;
      e.last = last;
      return e;
   endfunction

   // Compare process: samples at negedge, mid-cycle, away from the active edge
   initial begin
      beat_t e;
      logic [53:0] now;
      forever begin
         @(negedge aclk);
         now = {m_tvalid, m_tuser, m_tlast, m_tnumber, m_tcount, m_tdata};
         if (!aresetn) begin
            q.delete();
            foreach (mhist[k]) mhist[k] = 0;
            mfirst = 1'b1;
            pend = 1'b0;
            prev_stall = 1'b0;
         end else begin
            check("stat_valid", 256'(stat_valid), 256'(pend));
            if (pend) check("stat_hist", 256'(stat_class_pixels), 256'(exp_hist));
            if (stat_valid) begin
               stat_pulses++;
               last_hist = stat_class_pixels;
            end
            pend = 1'b0;
            if (prev_stall) check("stall_hold", 256'(now), 256'(held));
            if (s_tvalid && s_tready)
               q.push_back(model(s_tdata, s_tseg, param_bg_enable, param_min_count, s_tuser[0], s_tlast));
            if (m_tvalid && m_tready) begin
               outputs_seen++;
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_beat actual=%0h required=none", now);
               end else begin
                  e = q.pop_front();
                  check("beat", 256'({m_tuser, m_tlast, m_tnumber, m_tcount, m_tdata}), 256'(e));
                  if (e.user) begin
                     if (!mfirst) begin
                        for (int k = 0; k < NC; k++) exp_hist[k*SW +: SW] = SW'(mhist[k]);
                        pend = 1'b1;
                     end
                     mfirst = 1'b0;
                     foreach (mhist[k]) mhist[k] = 0;
                     mhist[e.num] = 1;
                  end else if (mhist[e.num] < (1 << SW) - 1) begin
                     mhist[e.num]++;
                  end
               end
            end
            prev_stall = m_tvalid && !m_tready;
            held = now;
         end
      end
   end

   // Presents one beat for exactly one capture edge (output side is kept ready)
   task automatic applyStimulus(input logic [VW-1:0] v, input logic seg, input logic user, input logic last);
      s_tdata  = v;
      s_tseg   = seg;
      s_tuser  = user;
      s_tlast  = last;
      s_tvalid = 1'b1;
      @(posedge aclk); #1;
      s_tvalid = 1'b0;
   endtask

   // Checks the exact 3-edge latency and the hand-computed result, then drains
   task automatic checkOutput(input string name, input logic [3:0] num, input logic [2:0] cnt,
                              input logic chk_data, input logic [VW-1:0] data);
      check({name, "_lat1"}, 256'(m_tvalid), 256'(0));
      @(posedge aclk); #1;
      check({name, "_lat2"}, 256'(m_tvalid), 256'(0));
      @(posedge aclk); #1;
      check({name, "_valid"}, 256'(m_tvalid), 256'(1));
      check({name, "_num"}, 256'(m_tnumber), 256'(num));
      check({name, "_cnt"}, 256'(m_tcount), 256'(cnt));
      if (chk_data) check({name, "_data"}, 256'(m_tdata), 256'(data));
      repeat (3) @(posedge aclk);
      #1;
   endtask

   task automatic drain();
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      repeat (8) @(posedge aclk);
      #1;
   endtask

   // Directed cases, then a randomized soak, then frame statistics
   initial begin
      logic [NC*SW-1:0] hexp;
      int accepted;
      int cycles;
      int out0;
      repeat (3) @(negedge aclk);
      check("rst_s_tready", 256'(s_tready), 256'(0));
      check("rst_m_tvalid", 256'(m_tvalid), 256'(0));
      check("rst_stat_valid", 256'(stat_valid), 256'(0));
      check("rst_stat_pixels", 256'(stat_class_pixels), 256'(0));
      @(posedge aclk); #1;
      aresetn = 1'b1;
      repeat (2) @(posedge aclk);
      #1;

      applyStimulus(44'h000_0000_F000, 1'b1, 1'b0, 1'b0);
      checkOutput("single", 4'd3, 3'd4, 1'b0, '0);
      applyStimulus(44'h000_C000_0300, 1'b1, 1'b0, 1'b0);
      checkOutput("tie", 4'd2, 3'd2, 1'b0, '0);
      applyStimulus(44'h123_4567_89AB, 1'b0, 1'b0, 1'b0);
      checkOutput("bg_force", 4'd10, 3'd4, 1'b1, 44'hF00_0000_0000);
      param_min_count = 3'd3;
      applyStimulus(44'h000_0050_0010, 1'b1, 1'b0, 1'b0);
      checkOutput("below_min", 4'd10, 3'd2, 1'b0, '0);
      param_min_count = 3'd0;
      applyStimulus(44'h000_0000_0000, 1'b1, 1'b0, 1'b0);
      checkOutput("all_zero", 4'd0, 3'd0, 1'b0, '0);
      param_bg_enable = 1'b0;
      param_min_count = 3'd1;
      applyStimulus(44'hF00_0000_0001, 1'b0, 1'b0, 1'b1);
      checkOutput("bg_off", 4'd10, 3'd4, 1'b1, 44'hF00_0000_0001);

      // Randomized soak with 50% output backpressure
      param_min_count = 3'($urandom_range(0, 4));
      accepted = 0;
      cycles = 0;
      out0 = outputs_seen;
      while (accepted < 1000 && cycles < 20000) begin
         s_tvalid        = ($urandom_range(0, 3) != 0);
         s_tdata         = VW'({$urandom(), $urandom()});
         s_tseg          = 1'($urandom());
         param_bg_enable = 1'($urandom());
         s_tuser         = ($urandom_range(0, 15) == 0);
         s_tlast         = 1'($urandom());
         m_tready        = 1'($urandom());
         @(negedge aclk);
         if (s_tvalid && s_tready) accepted++;
         @(posedge aclk); #1;
         cycles++;
      end
      check("soak_accepted", 256'(accepted), 256'(1000));
      drain();
      check("soak_out_count", 256'(outputs_seen - out0), 256'(accepted));
      check("soak_queue_empty", 256'(q.size()), 256'(0));

      // Reset in the middle of a frame discards all state
      param_bg_enable = 1'b1;
      param_min_count = 3'd1;
      for (int i = 0; i < 4; i++) applyStimulus(44'h000_0000_F000, 1'b1, i == 0, 1'b0);
      aresetn = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      @(posedge aclk); #1;
      stat_pulses = 0;

      // Frame 1: classes 0 and 4 alternate over 4x2 pixels
      for (int i = 0; i < 8; i++)
         applyStimulus((i % 2 == 0) ? 44'h000_0000_000F : 44'h000_000F_0000, 1'b1, i == 0, i % 4 == 3);
      drain();
      check("frame1_no_pulse", 256'(stat_pulses), 256'(0));
      // Frame 2: every winner is class 1
      for (int i = 0; i < 8; i++) applyStimulus(44'h000_0000_00F0, 1'b1, i == 0, i % 4 == 3);
      drain();
      hexp = '0;
      hexp[0*SW +: SW] = SW'(4);
      hexp[4*SW +: SW] = SW'(4);
      check("frame2_pulses", 256'(stat_pulses), 256'(1));
      check("frame2_hist", 256'(last_hist), 256'(hexp));
      // Frame 3 start publishes frame 2
      applyStimulus(44'h000_0000_F000, 1'b1, 1'b1, 1'b0);
      drain();
      hexp = '0;
      hexp[1*SW +: SW] = SW'(8);
      check("frame3_pulses", 256'(stat_pulses), 256'(2));
      check("frame3_hist", 256'(stat_class_pixels), 256'(hexp));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
